// File: rtl/uart_stim_pkg.sv
// Shared definitions for the UART stimulus transmitter.
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmit FSM state type
//   - calc_div(): rounded clocks-per-bit for a clock/baud pair
package uart_stim_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    GAP
  } state_t;

  // Round to nearest so the bit period error stays within half a clock.
  function automatic int calc_div(input longint clk_freq, input longint baud);
    return int'((clk_freq + (baud / 2)) / baud);
  endfunction

endpackage

// File: rtl/uart_stim_tx_if.sv
// Write-side and status bundle for uart_stim_tx.
//   master (producer / bench): drives wr_en, wr_data, bad_stop
//   slave  (uart_stim_tx)    : drives full, empty, count, ovf, busy, txd, dbg_state
//
// Handshake: wr_en is a one-cycle push strobe qualified by full, which acts
// as the inverse of ready. On any rising clk edge with wr_en=1 the entry
// {bad_stop, wr_data} is stored if full=0, or if the transmitter pops the
// head on that same edge; otherwise it is dropped and ovf latches high.
// There is no stall: the producer must watch full itself.
interface uart_stim_tx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  import uart_stim_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 bad_stop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 ovf;
  logic                 busy;
  logic                 txd;
  state_t               dbg_state;

  modport master (
    output wr_en, wr_data, bad_stop,
    input  full, empty, count, ovf, busy, txd, dbg_state
  );

  modport slave (
    input  wr_en, wr_data, bad_stop,
    output full, empty, count, ovf, busy, txd, dbg_state
  );

endinterface

// File: rtl/uart_stim_tx_fifo_sync.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write strobe and data
//   pop, rdata    : read strobe; rdata always shows the head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
// A push while full is still accepted when a pop happens on the same edge.
module fifo_sync #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// Framed UART stimulus generator: words pushed through the bus interface are
// queued in a FIFO and serialised on txd (LSB first) with optional parity,
// 1 or 2 stop bits, optional idle gap and per-word stop-bit corruption.
//   clk  : system clock
//   rst  : asynchronous active-high reset; txd returns high immediately
//   bus  : uart_stim_tx_if.slave -- wr_en/wr_data/bad_stop in;
//          full/empty/count/ovf/busy/txd/dbg_state out
// The interface DATA_BITS / FIFO_DEPTH must match this module's parameters.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_BITS   = 0
) (
  input logic           clk,
  input logic           rst,
  uart_stim_tx_if.slave bus
);

  localparam int DIV     = calc_div(CLK_FREQ, BAUD);
  localparam int BAUD_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BIT_MAX = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX);

  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_GAP  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  // Elaboration-time parameter checks.
  if (DIV < 2) begin : g_err_div
    $error("uart_stim_tx: bit period DIV=%0d must be at least 2", DIV);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_stim_tx: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_err_par
    $error("uart_stim_tx: PARITY=%0d is not 0, 1 or 2", PARITY);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_stim_tx: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("uart_stim_tx: FIFO_DEPTH=%0d must be a power of 2, at least 2", FIFO_DEPTH);
  end
  if (GAP_BITS < 0) begin : g_err_gap
    $error("uart_stim_tx: GAP_BITS=%0d must not be negative", GAP_BITS);
  end

  // FIFO entry layout: {bad_stop, payload}
  logic [DATA_BITS:0]   head;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_bad;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 par_q;
  logic                 bad_q;
  logic                 txd_q;
  logic                 ovf_q;
  logic                 baud_last;

  assign head_data = head[DATA_BITS-1:0];
  assign head_bad  = head[DATA_BITS];
  assign pop       = (state == IDLE) && !fifo_empty;
  assign baud_last = (baud_cnt == LAST_BAUD);

  fifo_sync #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .wdata ({bus.bad_stop, bus.wr_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.count)
  );

  // A write is only lost when full and nothing leaves on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  // Transmit FSM. txd is registered and preset by the async reset, so the
  // line goes high the moment rst rises. Each state's line level is loaded
  // on the edge that enters it; the baud counter wraps to 0 on every
  // transition, so it is already 0 whenever IDLE is re-entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      par_q    <= 1'b0;
      bad_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      if (state != IDLE) baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sh      <= head_data;
            par_q   <= (PARITY == PAR_EVEN) ? ^head_data : ~^head_data;
            bad_q   <= head_bad;
            bit_cnt <= '0;
            txd_q   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_last) begin
            txd_q <= sh[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                txd_q <= par_q;
                state <= PAR;
              end else begin
                txd_q <= ~bad_q;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sh      <= sh >> 1;
              txd_q   <= sh[1];
            end
          end
        end
        PAR: begin
          if (baud_last) begin
            bit_cnt <= '0;
            txd_q   <= ~bad_q;
            state   <= STOP;
          end
        end
        STOP: begin
          if (baud_last) begin
            txd_q <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= (GAP_BITS > 0) ? GAP : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (baud_last) begin
            if (bit_cnt == LAST_GAP) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state != IDLE);
  assign bus.txd       = txd_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_stim_tx.sv
module tb_uart_stim_tx;
  import uart_stim_pkg::*;

  localparam int DIV_DEF   = 434;  // 50 MHz / 115200, rounded
  localparam int DIV_SMALL = 16;   // 1600 / 100

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_stim_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
  uart_stim_tx_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if1 ();
  uart_stim_tx_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if2 ();
  uart_stim_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if3 ();
  uart_stim_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if4 ();
  uart_stim_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if5 ();

  uart_stim_tx u0 (.clk(clk), .rst(rst), .bus(if0));
  uart_stim_tx #(.DATA_BITS(7), .PARITY(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  uart_stim_tx #(.DATA_BITS(7), .PARITY(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  uart_stim_tx #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) u3 (.clk(clk), .rst(rst), .bus(if3));
  uart_stim_tx #(.CLK_FREQ(1600), .BAUD(100), .STOP_BITS(2)) u4 (.clk(clk), .rst(rst), .bus(if4));
  uart_stim_tx #(.CLK_FREQ(1600), .BAUD(100), .GAP_BITS(3)) u5 (.clk(clk), .rst(rst), .bus(if5));

  // ---------------- driver / sampling tasks ----------------
  function automatic logic txd_of(input int sel);
    case (sel)
      0: return if0.txd;
      1: return if1.txd;
      2: return if2.txd;
      3: return if3.txd;
      4: return if4.txd;
      default: return if5.txd;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0: return if0.busy;
      1: return if1.busy;
      2: return if2.busy;
      3: return if3.busy;
      4: return if4.busy;
      default: return if5.busy;
    endcase
  endfunction

  // 8N1 frame, index 0 = start bit
  function automatic logic [9:0] frame8(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Called just after a negedge; the push lands on the next posedge and
  // the task returns on the following negedge.
  task automatic push(input int sel, input logic [8:0] data, input logic bad);
    case (sel)
      0: begin if0.wr_en = 1'b1; if0.wr_data = data[7:0]; if0.bad_stop = bad; end
      1: begin if1.wr_en = 1'b1; if1.wr_data = data[6:0]; if1.bad_stop = bad; end
      2: begin if2.wr_en = 1'b1; if2.wr_data = data[6:0]; if2.bad_stop = bad; end
      3: begin if3.wr_en = 1'b1; if3.wr_data = data[7:0]; if3.bad_stop = bad; end
      4: begin if4.wr_en = 1'b1; if4.wr_data = data[7:0]; if4.bad_stop = bad; end
      default: begin if5.wr_en = 1'b1; if5.wr_data = data[7:0]; if5.bad_stop = bad; end
    endcase
    @(negedge clk);
    if0.wr_en = 1'b0; if1.wr_en = 1'b0; if2.wr_en = 1'b0;
    if3.wr_en = 1'b0; if4.wr_en = 1'b0; if5.wr_en = 1'b0;
  endtask

  // Samples n consecutive negedges, counting any where txd or busy differ.
  task automatic span(input int sel, input int n, input logic exp_txd,
                      input logic exp_busy, output int bad);
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (txd_of(sel) !== exp_txd || busy_of(sel) !== exp_busy) bad++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (if0.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", if0.txd); end
    n_cmp++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
    n_cmp++; if (if0.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", if0.full); end
    n_cmp++; if (if0.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", if0.empty); end
    n_cmp++; if (if0.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", if0.count); end
    n_cmp++; if (if0.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", if0.ovf); end
    n_cmp++; if (if0.dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", if0.dbg_state); end
    n_cmp++; if (if3.count !== 3'd0 || if3.empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_fifo4: count %0d empty %b want 0/1", if3.count, if3.empty);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [9:0] fv;
    int bad;
    fv = 10'h2AA;  // start 0, 0x55 LSB first, stop 1
    push(0, 9'h055, 1'b0);
    n_cmp++; if (if0.txd !== 1'b1) begin n_fail++; $display("FAIL basic_latency_e: txd %b want 1 right after write edge", if0.txd); end
    n_cmp++; if (if0.count !== 5'd1) begin n_fail++; $display("FAIL basic_count_after_write: got %0d want 1", if0.count); end
    @(negedge clk);
    n_cmp++; if (if0.txd !== 1'b0) begin n_fail++; $display("FAIL basic_latency_e1: txd %b want 0 from edge E+1", if0.txd); end
    for (int k = 0; k < 10; k++) begin
      span(0, DIV_DEF, fv[k], 1'b1, bad);
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL basic_bit%0d: %0d samples off, want txd=%b busy=1 for %0d clocks", k, bad, fv[k], DIV_DEF); end
    end
    n_cmp++; if (if0.busy !== 1'b0 || if0.txd !== 1'b1) begin
      n_fail++; $display("FAIL basic_end: busy %b txd %b want 0/1 after 4340 clocks", if0.busy, if0.txd);
    end
    n_cmp++; if (if0.empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", if0.empty); end
  endtask

  task automatic test_parity_even();
    logic [9:0] fv;
    int bad;
    fv = 10'h282;  // 0x41 in 7 bits, even parity bit 0
    push(1, 9'h041, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      span(1, DIV_DEF, fv[k], 1'b1, bad);
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL even_bit%0d: %0d samples off, want txd=%b", k, bad, fv[k]); end
    end
    n_cmp++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL even_end_busy: got %b want 0", if1.busy); end
  endtask

  task automatic test_parity_odd();
    logic [9:0] fv;
    int bad;
    fv = 10'h382;  // same payload, odd parity bit 1
    push(2, 9'h041, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      span(2, DIV_DEF, fv[k], 1'b1, bad);
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL odd_bit%0d: %0d samples off, want txd=%b", k, bad, fv[k]); end
    end
    n_cmp++; if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL odd_end_busy: got %b want 0", if2.busy); end
  endtask

  task automatic test_fifo_burst();
    logic [7:0] d [6];
    logic [9:0] fv;
    int bad;
    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 5; i++) push(3, {1'b0, d[i]}, 1'b0);
    n_cmp++; if (if3.count !== 3'd4 || if3.full !== 1'b1 || if3.ovf !== 1'b0) begin
      n_fail++; $display("FAIL burst_fill: count %0d full %b ovf %b want 4/1/0", if3.count, if3.full, if3.ovf);
    end
    push(3, {1'b0, d[5]}, 1'b0);
    n_cmp++; if (if3.count !== 3'd4 || if3.ovf !== 1'b1) begin
      n_fail++; $display("FAIL burst_drop: count %0d ovf %b want 4/1", if3.count, if3.ovf);
    end
    // Five frames back-to-back; the first started 5 clocks ago.
    for (int f = 0; f < 5; f++) begin
      fv = frame8(d[f]);
      for (int k = 0; k < 10; k++) begin
        span(3, (f == 0 && k == 0) ? DIV_SMALL - 4 : DIV_SMALL, fv[k], 1'b1, bad);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL burst_f%0d_bit%0d: %0d samples off, want txd=%b", f, k, bad, fv[k]); end
      end
      n_cmp++; if (if3.txd !== 1'b1 || if3.busy !== 1'b0) begin
        n_fail++; $display("FAIL burst_idle%0d: txd %b busy %b want 1/0", f, if3.txd, if3.busy);
      end
      @(negedge clk);
    end
    n_cmp++; if (if3.busy !== 1'b0 || if3.empty !== 1'b1 || if3.count !== 3'd0) begin
      n_fail++; $display("FAIL burst_done: busy %b empty %b count %0d want 0/1/0", if3.busy, if3.empty, if3.count);
    end
    n_cmp++; if (if3.ovf !== 1'b1) begin n_fail++; $display("FAIL burst_ovf_sticky: got %b want 1", if3.ovf); end
  endtask

  task automatic test_bad_stop();
    logic [10:0] fv [2];
    int bad;
    fv = '{11'h54A, 11'h678};  // 0xA5 with first stop 0; 0x3C clean
    push(4, 9'h0A5, 1'b1);
    push(4, 9'h03C, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 11; k++) begin
        span(4, DIV_SMALL, fv[f][k], 1'b1, bad);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL badstop_f%0d_bit%0d: %0d samples off, want txd=%b", f, k, bad, fv[f][k]); end
      end
      n_cmp++; if (if4.txd !== 1'b1 || if4.busy !== 1'b0) begin
        n_fail++; $display("FAIL badstop_idle%0d: txd %b busy %b want 1/0", f, if4.txd, if4.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    logic [12:0] fv [2];
    int bad;
    fv = '{13'h1E1E, 13'h1FE0};  // 0x0F and 0xF0, each + 3 gap periods
    push(5, 9'h00F, 1'b0);
    push(5, 9'h0F0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 13; k++) begin
        span(5, DIV_SMALL, fv[f][k], 1'b1, bad);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL gap_f%0d_bit%0d: %0d samples off, want txd=%b busy=1", f, k, bad, fv[f][k]); end
      end
      n_cmp++; if (if5.txd !== 1'b1 || if5.busy !== 1'b0) begin
        n_fail++; $display("FAIL gap_idle%0d: txd %b busy %b want 1/0", f, if5.txd, if5.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    push(3, 9'h011, 1'b0);
    push(3, 9'h000, 1'b0);
    push(3, 9'h022, 1'b0);
    // Frame 2 starts at E+162; data bit 3 covers E+226..E+241.
    repeat (228) @(negedge clk);
    n_cmp++; if (if3.txd !== 1'b0 || if3.dbg_state !== DATA || if3.count !== 3'd1) begin
      n_fail++; $display("FAIL rstmid_pre: txd %b state %0d count %0d want 0/DATA/1", if3.txd, if3.dbg_state, if3.count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if3.txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd_async: got %b want 1", if3.txd); end
    n_cmp++; if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", if3.busy); end
    n_cmp++; if (if3.count !== 3'd0 || if3.empty !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fifo: count %0d empty %b want 0/1", if3.count, if3.empty);
    end
    n_cmp++; if (if3.ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b want 0", if3.ovf); end
    @(negedge clk);
    rst = 1'b0;
    span(3, 400, 1'b1, 1'b0, bad);
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d samples with activity, want none", bad); end
    n_cmp++; if (if3.empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty_after: got %b want 1", if3.empty); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if0.wr_en = 1'b0; if0.wr_data = '0; if0.bad_stop = 1'b0;
    if1.wr_en = 1'b0; if1.wr_data = '0; if1.bad_stop = 1'b0;
    if2.wr_en = 1'b0; if2.wr_data = '0; if2.bad_stop = 1'b0;
    if3.wr_en = 1'b0; if3.wr_data = '0; if3.bad_stop = 1'b0;
    if4.wr_en = 1'b0; if4.wr_data = '0; if4.bad_stop = 1'b0;
    if5.wr_en = 1'b0; if5.wr_data = '0; if5.bad_stop = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_parity_even();
    test_parity_odd();
    test_fifo_burst();
    test_bad_stop();
    test_gap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
